id_operand_stage: RTL and testbench

- Decode/operand-fetch pipeline stage sitting directly downstream of registerFile.
- Splits the 32-bit instruction, drives the register file read addresses (R1/R2) and captures its combinational read data (Out1/Out2) into an ID/EX register.
- Tracks in-flight destination registers with an 8-bit scoreboard and stalls on RAW hazards.
- Valid/ready handshake on both sides; flush from branch resolution.

---
 rtl/id_pkg.sv | 45 ++++
 rtl/id_operand_stage_scoreboard.sv | 41 ++++
 rtl/id_operand_stage.sv | 116 +++++++++++
 tb/tb_id_operand_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID/operand-fetch stage: opcodes, field
// positions, default widths and per-opcode register-use helpers.
package id_pkg;

  localparam int ID_DATA_W  = 32;
  localparam int ID_ADDR_W  = 3;
  localparam int ID_INSTR_W = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 23;
  localparam int RS_HI  = 22;
  localparam int RS_LO  = 20;
  localparam int RT_HI  = 19;
  localparam int RT_LO  = 17;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_ADDI = 6'd4,
    OP_LW   = 6'd5,
    OP_SW   = 6'd6,
    OP_BEQ  = 6'd7,
    OP_NOP  = 6'd63
  } opcode_e;

  function automatic logic writes_rd(input logic [5:0] op);
    return op <= OP_LW;
  endfunction

  // Undefined opcodes behave as NOP, so only the eight real ones read rs.
  function automatic logic uses_rs(input logic [5:0] op);
    return op <= OP_BEQ;
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW, OP_BEQ};
  endfunction

endpackage

// File: rtl/id_operand_stage_scoreboard.sv
// Pending-write mask, one bit per architectural register. A set in the same
// cycle as a writeback clear or flush kill of the same register wins.
module id_scoreboard
  import id_pkg::*;
#(
  parameter  int ADDR_W = ID_ADDR_W,
  localparam int NREG   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              pend_a,
  output logic              pend_b
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en)  pend_d[clr_addr]  = 1'b0;
    if (kill_en) pend_d[kill_addr] = 1'b0;
    if (set_en)  pend_d[set_addr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend_a = pend_q[rd_addr_a];
  assign pend_b = pend_q[rd_addr_b];

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: drives register-file read ports, stalls on RAW
// hazards via a scoreboard, and holds decoded operands in the ID/EX register.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data instead of stalling.
module id_operand_stage
  import id_pkg::*;
#(
  parameter int DATA_W  = ID_DATA_W,
  parameter int ADDR_W  = ID_ADDR_W,
  parameter int INSTR_W = ID_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [ADDR_W-1:0]  rf_r1,
  output logic [ADDR_W-1:0]  rf_r2,
  input  logic [DATA_W-1:0]  rf_out1,
  input  logic [DATA_W-1:0]  rf_out2,
  input  logic               wb_we,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         out_opcode,
  output logic [ADDR_W-1:0]  out_rd,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_wr,
  output logic               stall
);

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] rd, rs, rt;
  logic [15:0]       imm;
  logic              unused_bits;

  assign opcode      = in_instr[OP_HI:OP_LO];
  assign rd          = in_instr[RD_HI:RD_LO];
  assign rs          = in_instr[RS_HI:RS_LO];
  assign rt          = in_instr[RT_HI:RT_LO];
  assign imm         = in_instr[IMM_HI:IMM_LO];
  assign unused_bits = in_instr[16];

  assign rf_r1 = rs;
  assign rf_r2 = rt;

  logic use_rs, use_rt, wr;
  assign use_rs = uses_rs(opcode);
  assign use_rt = uses_rt(opcode);
  assign wr     = writes_rd(opcode);

  logic byp_rs, byp_rt;
`ifdef WB_BYPASS_EN
  assign byp_rs = wb_we && (wb_addr == rs);
  assign byp_rt = wb_we && (wb_addr == rt);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  logic [DATA_W-1:0] opnd_a, opnd_b;
  assign opnd_a = byp_rs ? wb_data : rf_out1;
  assign opnd_b = byp_rt ? wb_data : rf_out2;

  logic pend_rs, pend_rt, hazard, accept;
  assign hazard   = in_valid && ((use_rs && pend_rs && !byp_rs) ||
                                 (use_rt && pend_rt && !byp_rt));
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign stall    = in_valid && hazard;
  assign accept   = in_valid && in_ready;

  // Killing a flushed instruction's pending bit only makes sense while it is
  // still resident; once it has fired, out_rd is stale.
  id_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (accept && wr),
    .set_addr  (rd),
    .clr_en    (wb_we),
    .clr_addr  (wb_addr),
    .kill_en   (flush && out_valid && out_wr),
    .kill_addr (out_rd),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .pend_a    (pend_rs),
    .pend_b    (pend_rt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_imm    <= '0;
      out_wr     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= opcode;
      out_rd     <= rd;
      out_a      <= opnd_a;
      out_b      <= opnd_b;
      out_imm    <= {{(DATA_W-16){imm[15]}}, imm};
      out_wr     <= wr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with a behavioural reference model and
// a register-file model feeding rf_out1/rf_out2.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0;
  logic [2:0]  rf_r1, rf_r2;
  logic [31:0] rf_out1, rf_out2;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [5:0]  out_opcode;
  logic [2:0]  out_rd;
  logic [31:0] out_a, out_b, out_imm;
  logic        out_wr, stall;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_out1(rf_out1),
    .rf_out2(rf_out2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_a(out_a), .out_b(out_b),
    .out_imm(out_imm), .out_wr(out_wr), .stall(stall)
  );

  // Register file: combinational read, write on the clock edge.
  logic [31:0] rf [8];
  assign rf_out1 = rf[rf_r1];
  assign rf_out2 = rf[rf_r2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 8; i++) rf[i] <= '0;
    else if (wb_we) rf[wb_addr] <= wb_data;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt,
                                     input logic [15:0] imm);
    return {op, rd, rs, rt, 1'b0, imm};
  endfunction

  // Reference model
  bit          pend [8];
  bit          m_valid, m_wr;
  logic [5:0]  m_op;
  logic [2:0]  m_rd;
  logic [31:0] m_a, m_b, m_imm;

  function automatic bit m_reads_rs(input logic [5:0] op); return op < 8; endfunction
  function automatic bit m_reads_rt(input logic [5:0] op);
    return op == 0 || op == 1 || op == 2 || op == 3 || op == 6 || op == 7;
  endfunction
  function automatic bit m_byp(input logic [2:0] r);
`ifdef WB_BYPASS_EN
    return wb_we && wb_addr == r;
`else
    return 1'b0;
`endif
  endfunction
  function automatic bit m_hazard();
    logic [5:0] op = in_instr[31:26];
    logic [2:0] rs = in_instr[22:20];
    logic [2:0] rt = in_instr[19:17];
    return in_valid && ((m_reads_rs(op) && pend[rs] && !m_byp(rs)) ||
                        (m_reads_rt(op) && pend[rt] && !m_byp(rt)));
  endfunction
  function automatic bit m_ready();
    return !m_hazard() && (!m_valid || out_ready) && !flush;
  endfunction
  function automatic logic [7:0] m_mask();
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) m[i] = pend[i];
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_wr = 0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0; m_imm = '0;
      for (int i = 0; i < 8; i++) pend[i] = 0;
    end else begin
      bit acc;
      logic [2:0] rs, rt;
      acc = in_valid && m_ready();
      rs = in_instr[22:20];
      rt = in_instr[19:17];
      if (flush) begin
        if (m_valid && m_wr) pend[m_rd] = 0;
        m_valid = 0;
      end
      if (wb_we) pend[wb_addr] = 0;
      if (acc) begin
        m_valid = 1;
        m_op  = in_instr[31:26];
        m_rd  = in_instr[25:23];
        m_a   = m_byp(rs) ? wb_data : rf[rs];
        m_b   = m_byp(rt) ? wb_data : rf[rt];
        m_imm = $signed(in_instr[15:0]);
        m_wr  = m_op < 6;
        if (m_wr) pend[m_rd] = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("stall", 32'(stall), 32'(m_hazard()));
      chk("rf_r1", 32'(rf_r1), 32'(in_instr[22:20]));
      chk("rf_r2", 32'(rf_r2), 32'(in_instr[19:17]));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("scoreboard", 32'(dut.u_sb.pend_q), 32'(m_mask()));
      if (m_valid) begin
        chk("out_opcode", 32'(out_opcode), 32'(m_op));
        chk("out_rd", 32'(out_rd), 32'(m_rd));
        chk("out_a", out_a, m_a);
        chk("out_b", out_b, m_b);
        chk("out_imm", out_imm, m_imm);
        chk("out_wr", 32'(out_wr), 32'(m_wr));
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic wb(input logic [2:0] a, input logic [31:0] d);
    wb_we = 1; wb_addr = a; wb_data = d; cyc(); wb_we = 0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_a", out_a, 0);
    chk("rst_sb", 32'(dut.u_sb.pend_q), 0);
    @(posedge clk); #1; rst_n = 1;
    wb(3'd1, 32'hFFFF_FFFF);
    wb(3'd2, 32'hAAAA_AAAA);

    // Simple issue: ADD r3 = r1 + r2, then dependent SUB r4 = r3 - r1
    out_ready = 1; in_valid = 1; in_instr = mk(6'd0, 3'd3, 3'd1, 3'd2, 16'h0);
    cyc();
    in_instr = mk(6'd1, 3'd4, 3'd3, 3'd1, 16'h0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_a", out_a, 32'hFFFF_FFFF);
    chk("add_b", out_b, 32'hAAAA_AAAA);
    chk("add_sb3", 32'(dut.u_sb.pend_q[3]), 1);
    chk("raw_stall", 32'(stall), 1);
    chk("raw_ready", 32'(in_ready), 0);
    cyc();
    wb_we = 1; wb_addr = 3'd3; wb_data = 32'h1234_5678;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("wb_cycle_stall", 32'(stall), 0);
`else
    chk("wb_cycle_stall", 32'(stall), 1);
`endif
    cyc();
    wb_we = 0;
`ifdef WB_BYPASS_EN
    in_valid = 0;
    @(negedge clk);
    chk("byp_a", out_a, 32'h1234_5678);
`else
    @(negedge clk);
    chk("post_wb_ready", 32'(in_ready), 1);
`endif
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("sub_a", out_a, 32'h1234_5678);
    chk("sub_op", 32'(out_opcode), 1);
    cyc();

    // Backpressure
    in_valid = 1; in_instr = mk(6'd2, 3'd6, 3'd1, 3'd2, 16'h0);
    cyc();
    out_ready = 0; in_instr = mk(6'd3, 3'd7, 3'd2, 3'd1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_op", 32'(out_opcode), 2);
      chk("bp_a", out_a, 32'hFFFF_FFFF);
      cyc();
    end
    out_ready = 1;
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("rel_op", 32'(out_opcode), 3);
    chk("rel_a", out_a, 32'hAAAA_AAAA);
    chk("rel_b", out_b, 32'hFFFF_FFFF);
    wb(3'd4, 32'h4444_4444);
    wb(3'd6, 32'h6666_6666);
    wb(3'd7, 32'h7777_7777);

    // Flush: LW r5 held, then killed
    out_ready = 0; in_valid = 1; in_instr = mk(6'd5, 3'd5, 3'd1, 3'd0, 16'h0004);
    cyc();
    in_instr = mk(6'd0, 3'd7, 3'd5, 3'd5, 16'h0);
    flush = 1;
    @(negedge clk);
    chk("fl_ready", 32'(in_ready), 0);
    chk("fl_sb5_before", 32'(dut.u_sb.pend_q[5]), 1);
    cyc();
    flush = 0;
    @(negedge clk);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_sb5", 32'(dut.u_sb.pend_q[5]), 0);
    chk("fl_stall", 32'(stall), 0);
    chk("fl_next_ready", 32'(in_ready), 1);
    cyc();

    // Simultaneous set/clear on r0, negative immediate
    out_ready = 1; in_instr = mk(6'd4, 3'd0, 3'd1, 3'd0, 16'h8000);
    wb_we = 1; wb_addr = 3'd0; wb_data = 32'h0000_0BAD;
    cyc();
    wb_we = 0; out_ready = 0;
    in_instr = mk(6'd20, 3'd1, 3'd7, 3'd7, 16'h0001);
    @(negedge clk);
    chk("ss_sb0", 32'(dut.u_sb.pend_q[0]), 1);
    chk("ss_imm", out_imm, 32'hFFFF_8000);
    chk("ss_wr", 32'(out_wr), 1);
    chk("undef_stall", 32'(stall), 0);
    out_ready = 1;
    cyc();
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("undef_wr", 32'(out_wr), 0);
    chk("undef_op", 32'(out_opcode), 20);

    // Asynchronous reset mid-transfer
    in_valid = 1; out_ready = 1; in_instr = mk(6'd5, 3'd2, 3'd1, 3'd0, 16'h0010);
    cyc();
    in_valid = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_sb", 32'(dut.u_sb.pend_q), 0);
    chk("arst_a", out_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
